// File: rtl/mem_bus_ctrl_pkg.sv
// Shared memory-map constants and types for the CPU memory-bus controller.
// Holds the DMA state encoding and the read-return source tag.
package mem_bus_ctrl_pkg;

  localparam int          DMA_LEN_DEF   = 160;
  localparam logic [15:0] OAM_BASE_DEF  = 16'hFE00;
  localparam logic [15:0] DMA_REG_DEF   = 16'hFF46;
  localparam logic [15:0] HRAM_BASE_DEF = 16'hFF80;
  localparam logic [15:0] HRAM_LAST     = 16'hFFFE;
  localparam logic [15:0] ECHO_LO       = 16'hE000;
  localparam logic [15:0] ECHO_HI       = 16'hFDFF;
  localparam logic [15:0] ECHO_OFS      = 16'h2000;
  localparam logic [15:0] UNUSED_LO     = 16'hFEA0;
  localparam logic [15:0] UNUSED_HI     = 16'hFEFF;

  typedef enum logic [1:0] {IDLE, SETUP, RD, WR} dma_state_t;

  typedef enum logic [1:0] {MEM, HRAM, DMAREG, CONST_FF} rdata_src_t;

  typedef enum logic [1:0] {REG_MEM, REG_UNUSABLE, REG_DMA, REG_HRAM} region_t;

  // Source pages in the echo range are folded back onto work RAM.
  function automatic logic [7:0] dma_src_hi(input logic [7:0] v);
    return (v >= 8'hE0) ? v - 8'h20 : v;
  endfunction

endpackage

// File: rtl/mem_bus_ctrl_hram.sv
// 127-byte high RAM: synchronous write, synchronous registered read.
// The read port updates only on a read request so the last result is held.
module hram_127x8 (
  input  logic       clk,
  input  logic       we,
  input  logic       re,
  input  logic [6:0] idx,
  input  logic [7:0] wdata,
  output logic [7:0] rdata
);

  logic [7:0] mem [0:126];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
    if (re) rdata <= mem[idx];
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Memory-bus controller: CPU access decode, echo remap, HRAM, FF46 register
// and the OAM DMA engine that owns the external port while it runs.
module mem_bus_ctrl
  import mem_bus_ctrl_pkg::*;
#(
  parameter int          DMA_LEN   = DMA_LEN_DEF,
  parameter logic [15:0] OAM_BASE  = OAM_BASE_DEF,
  parameter logic [15:0] DMA_REG   = DMA_REG_DEF,
  parameter logic [15:0] HRAM_BASE = HRAM_BASE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_re,
  input  logic        cpu_we,
  output logic [7:0]  cpu_rdata,
  output logic        dma_active,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_re,
  output logic        mem_we,
  input  logic [7:0]  mem_rdata
);

  localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

  dma_state_t state;
  logic [7:0] idx;
  logic [7:0] dma_reg;
  rdata_src_t tag_p1;

  region_t     region;
  logic [15:0] phys_addr;
  logic [15:0] dma_src_addr;
  logic [6:0]  hram_idx;
  logic        hram_we;
  logic        hram_re;
  logic [7:0]  hram_q;
  logic        dma_start;
  logic        cpu_rd;

  always_comb begin
    region = REG_MEM;
    if (cpu_addr == DMA_REG)
      region = REG_DMA;
    else if (cpu_addr >= HRAM_BASE && cpu_addr <= HRAM_LAST)
      region = REG_HRAM;
    else if (cpu_addr >= UNUSED_LO && cpu_addr <= UNUSED_HI)
      region = REG_UNUSABLE;
  end

  assign phys_addr = (cpu_addr >= ECHO_LO && cpu_addr <= ECHO_HI) ?
                     cpu_addr - ECHO_OFS : cpu_addr;

  // A simultaneous write takes priority, so a read only counts without one.
  assign cpu_rd     = cpu_re && !cpu_we;
  assign dma_start  = cpu_we && (region == REG_DMA);
  assign hram_we    = cpu_we && (region == REG_HRAM);
  assign hram_re    = cpu_rd && (region == REG_HRAM);
  assign hram_idx   = cpu_addr[6:0] - HRAM_BASE[6:0];
  assign dma_active = (state != IDLE);

  // idx stays below 256, so the low-byte add never carries into the page.
  assign dma_src_addr = {dma_src_hi(dma_reg), 8'h00} + {8'h00, idx};

  hram_127x8 u_hram (
    .clk   (clk),
    .we    (hram_we),
    .re    (hram_re),
    .idx   (hram_idx),
    .wdata (cpu_wdata),
    .rdata (hram_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= 8'h00;
      dma_reg <= 8'hFF;
      tag_p1  <= CONST_FF;
    end else begin
      if (dma_start) begin
        dma_reg <= cpu_wdata;
        state   <= SETUP;
        idx     <= 8'h00;
      end else begin
        unique case (state)
          IDLE:  state <= IDLE;
          SETUP: state <= WR;
          RD:    state <= WR;
          WR: begin
            state <= (idx == LAST_IDX) ? IDLE : RD;
            idx   <= idx + 8'h01;
          end
        endcase
      end
      if (cpu_rd) begin
        unique case (region)
          REG_HRAM: tag_p1 <= HRAM;
          REG_DMA:  tag_p1 <= DMAREG;
          REG_MEM:  tag_p1 <= dma_active ? CONST_FF : MEM;
          default:  tag_p1 <= CONST_FF;
        endcase
      end
    end
  end

  // SETUP already fetches byte 0, so each later byte costs one RD/WR pair
  // and the whole transfer spans 1 + 2*DMA_LEN - 1 cycles.
  always_comb begin
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 16'h0000;
    mem_wdata = 8'h00;
    unique case (state)
      SETUP, RD: begin
        mem_re   = 1'b1;
        mem_addr = dma_src_addr;
      end
      WR: begin
        mem_we    = 1'b1;
        mem_addr  = OAM_BASE + {8'h00, idx};
        mem_wdata = mem_rdata;
      end
      IDLE: begin
        if (cpu_we && region == REG_MEM) begin
          mem_we    = 1'b1;
          mem_addr  = phys_addr;
          mem_wdata = cpu_wdata;
        end else if (cpu_re && !cpu_we && region == REG_MEM) begin
          mem_re   = 1'b1;
          mem_addr = phys_addr;
        end
      end
    endcase
  end

  always_comb begin
    unique case (tag_p1)
      MEM:     cpu_rdata = mem_rdata;
      HRAM:    cpu_rdata = hram_q;
      DMAREG:  cpu_rdata = dma_reg;
      default: cpu_rdata = 8'hFF;
    endcase
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Bench for mem_bus_ctrl: external memory responder, transaction-level
// reference model, decode vector table, DMA corner sequences, random traffic.
module tb_mem_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cpu_addr = 16'h0;
  logic [7:0]  cpu_wdata = 8'h0;
  logic        cpu_re = 1'b0;
  logic        cpu_we = 1'b0;
  logic [7:0]  cpu_rdata;
  logic        dma_active;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_re;
  logic        mem_we;
  logic [7:0]  mem_rdata = 8'h0;

  mem_bus_ctrl dut (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_rdata(cpu_rdata),
    .dma_active(dma_active), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_re(mem_re), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [7:0] ext_mem [0:65535];
  always @(posedge clk) begin
    if (mem_we) ext_mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ext_mem[mem_addr];
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model state
  logic [7:0]  ref_mem [0:65535];
  logic [7:0]  m_hram [0:126];
  logic [7:0]  m_ff46;
  int          dma_start = -1;
  logic [15:0] dma_src;
  bit          pend_valid;
  bit          pend_live_reg;
  logic [7:0]  pend_val;

  // Sampled outputs of the last step
  logic        s_re, s_we, s_act;
  logic [15:0] s_addr;
  logic [7:0]  s_wd, s_rdata;

  function automatic logic [7:0] init_val(input int a);
    return 8'((a * 13) ^ (a >> 8));
  endfunction

  function automatic int region_of(input logic [15:0] a);
    if (a == 16'hFF46) return 2;
    if (a >= 16'hFF80 && a <= 16'hFFFE) return 3;
    if (a >= 16'hFEA0 && a <= 16'hFEFF) return 1;
    return 0;
  endfunction

  function automatic logic [15:0] phys(input logic [15:0] a);
    return (a >= 16'hE000 && a <= 16'hFDFF) ? a - 16'h2000 : a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input logic re, input logic we, input logic [15:0] a,
                      input logic [7:0] wd, input logic r);
    logic act, e_re, e_we;
    logic [15:0] e_a;
    logic [7:0] e_wd;
    int off, k, reg_n;
    @(negedge clk);
    rst = r; cpu_re = re; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    #1;
    s_re = mem_re; s_we = mem_we; s_act = dma_active;
    s_addr = mem_addr; s_wd = mem_wdata; s_rdata = cpu_rdata;
    if (pend_valid && !r)
      chk("cpu_rdata", cpu_rdata, pend_live_reg ? m_ff46 : pend_val);

    reg_n = region_of(a);
    act = dma_start >= 0 && cyc >= dma_start + 1 && cyc <= dma_start + 320;
    e_re = 0; e_we = 0; e_a = 16'h0; e_wd = 8'h0;
    if (act) begin
      off = cyc - dma_start;
      if (off % 2 == 1) begin
        e_re = 1; e_a = dma_src + 16'((off - 1) / 2);
      end else begin
        k = (off - 2) / 2;
        e_we = 1; e_a = 16'hFE00 + 16'(k); e_wd = ref_mem[dma_src + 16'(k)];
      end
    end else if (reg_n == 0 && we) begin
      e_we = 1; e_a = phys(a); e_wd = wd;
    end else if (reg_n == 0 && re) begin
      e_re = 1; e_a = phys(a);
    end
    if (!r) begin
      chk("dma_active", dma_active, act);
      chk("mem_re", mem_re, e_re);
      chk("mem_we", mem_we, e_we);
      if (e_re || e_we) chk("mem_addr", mem_addr, e_a);
      if (e_we) chk("mem_wdata", mem_wdata, e_wd);
    end
    if (e_we) ref_mem[e_a] = e_wd;
    if (dma_start >= 0 && cyc >= dma_start + 320) dma_start = -1;

    pend_valid = 0; pend_live_reg = 0; pend_val = 8'hFF;
    if (we) begin
      if (reg_n == 2) begin
        m_ff46 = wd; dma_start = cyc;
        dma_src = {((wd >= 8'hE0) ? wd - 8'h20 : wd), 8'h00};
      end
      if (reg_n == 3) m_hram[a - 16'hFF80] = wd;
    end else if (re) begin
      pend_valid = 1;
      case (reg_n)
        3: pend_val = m_hram[a - 16'hFF80];
        2: pend_live_reg = 1;
        0: pend_val = act ? 8'hFF : ref_mem[phys(a)];
        default: pend_val = 8'hFF;
      endcase
    end
    if (r) begin
      dma_start = -1; m_ff46 = 8'hFF;
      pend_valid = 1; pend_live_reg = 0; pend_val = 8'hFF;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 16'h0, 8'h0, 0);
  endtask

  typedef struct {
    logic re; logic we; logic [15:0] addr; logic [7:0] wd;
    logic e_re; logic e_we; logic [15:0] e_addr; logic [7:0] e_wd;
    logic c_rd; logic [7:0] e_rd;
  } vec_t;

  vec_t tbl [12];
  int   n_oam, start_n, restart_m;
  logic [7:0] v;
  int   op, sel;
  logic [15:0] ra;

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 16'hC123, 8'h5A, 1'b0, 1'b1, 16'hC123, 8'h5A, 1'b0, 8'h00};
    tbl[1]  = '{1'b1, 1'b0, 16'hC123, 8'h00, 1'b1, 1'b0, 16'hC123, 8'h00, 1'b0, 8'h00};
    tbl[2]  = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 8'h5A};
    tbl[3]  = '{1'b1, 1'b0, 16'hE123, 8'h00, 1'b1, 1'b0, 16'hC123, 8'h00, 1'b0, 8'h00};
    tbl[4]  = '{1'b0, 1'b1, 16'hFEB0, 8'h11, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 8'h5A};
    tbl[5]  = '{1'b1, 1'b0, 16'hFEB0, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h00};
    tbl[6]  = '{1'b0, 1'b1, 16'hFF90, 8'h77, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 8'hFF};
    tbl[7]  = '{1'b1, 1'b0, 16'hFF90, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h00};
    tbl[8]  = '{1'b1, 1'b1, 16'hC200, 8'h33, 1'b0, 1'b1, 16'hC200, 8'h33, 1'b1, 8'h77};
    tbl[9]  = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 8'h77};
    tbl[10] = '{1'b1, 1'b0, 16'hFF46, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h00};
    tbl[11] = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 8'hFF};

    for (int i = 0; i < 65536; i++) begin
      ext_mem[i] = init_val(i);
      ref_mem[i] = init_val(i);
    end
    m_ff46 = 8'hFF;

    step(0, 0, 16'h0, 8'h0, 1);
    step(0, 0, 16'h0, 8'h0, 1);
    step(0, 0, 16'h0, 8'h0, 0);
    chk("rst_dma_active", s_act, 0);
    chk("rst_mem_re", s_re, 0);
    chk("rst_mem_we", s_we, 0);
    chk("rst_mem_addr", s_addr, 0);
    chk("rst_mem_wdata", s_wd, 0);
    chk("rst_cpu_rdata", s_rdata, 8'hFF);

    // Decode vectors
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].re, tbl[i].we, tbl[i].addr, tbl[i].wd, 0);
      chk("vec_mem_re", s_re, tbl[i].e_re);
      chk("vec_mem_we", s_we, tbl[i].e_we);
      if (tbl[i].e_re || tbl[i].e_we) chk("vec_mem_addr", s_addr, tbl[i].e_addr);
      if (tbl[i].e_we) chk("vec_mem_wdata", s_wd, tbl[i].e_wd);
      if (tbl[i].c_rd) chk("vec_cpu_rdata", s_rdata, tbl[i].e_rd);
    end

    // Full DMA from C000 with known source bytes
    for (int i = 0; i < 160; i++) step(0, 1, 16'hC000 + 16'(i), 8'(i) ^ 8'hA5, 0);
    start_n = cyc;
    step(0, 1, 16'hFF46, 8'hC0, 0);
    n_oam = 0;
    for (int j = 0; j < 325; j++) begin
      step(0, 0, 16'h0, 8'h0, 0);
      if (cyc - 1 == start_n + 1)   chk("dma_first_active", s_act, 1);
      if (cyc - 1 == start_n + 320) chk("dma_last_active", s_act, 1);
      if (cyc - 1 == start_n + 321) chk("dma_idle_after", s_act, 0);
      if (s_we && s_addr >= 16'hFE00 && s_addr <= 16'hFE9F) begin
        chk("oam_addr", s_addr, 16'hFE00 + 16'(n_oam));
        chk("oam_data", s_wd, 8'(n_oam) ^ 8'hA5);
        n_oam++;
      end
    end
    chk("oam_write_count", n_oam, 160);

    // CPU traffic while DMA runs
    step(0, 1, 16'hFF46, 8'hC0, 0);
    idle(3);
    step(1, 0, 16'h8000, 8'h0, 0);
    chk("dma_blocks_cpu_addr", s_addr == 16'h8000, 0);
    step(0, 1, 16'hFF90, 8'h3C, 0);
    chk("dma_blocked_read_ff", s_rdata, 8'hFF);
    step(1, 0, 16'hFF90, 8'h0, 0);
    step(1, 0, 16'hFF46, 8'h0, 0);
    chk("dma_hram_read", s_rdata, 8'h3C);
    step(0, 0, 16'h0, 8'h0, 0);
    chk("dma_reg_read", s_rdata, 8'hC0);
    idle(320);

    // Restart after byte 50
    start_n = cyc;
    step(0, 1, 16'hFF46, 8'hC0, 0);
    idle(102);
    restart_m = cyc;
    step(0, 1, 16'hFF46, 8'hD0, 0);
    n_oam = 0;
    for (int j = 0; j < 325; j++) begin
      step(0, 0, 16'h0, 8'h0, 0);
      if (cyc - 1 == restart_m + 1) begin
        chk("restart_setup_re", s_re, 1);
        chk("restart_src_addr", s_addr, 16'hD000);
      end
      if (s_we && s_addr >= 16'hFE00 && s_addr <= 16'hFE9F) begin
        chk("restart_oam_addr", s_addr, 16'hFE00 + 16'(n_oam));
        chk("restart_oam_data", s_wd, init_val(32'hD000 + n_oam));
        n_oam++;
      end
    end
    chk("restart_write_count", n_oam, 160);
    chk("restart_idle", s_act, 0);

    // Reset at byte 80
    step(0, 1, 16'hFF46, 8'hC0, 0);
    idle(162);
    step(0, 0, 16'h0, 8'h0, 1);
    step(0, 0, 16'h0, 8'h0, 0);
    chk("abort_dma_active", s_act, 0);
    chk("abort_mem_re", s_re, 0);
    chk("abort_mem_we", s_we, 0);
    step(1, 0, 16'hFF46, 8'h0, 0);
    step(0, 0, 16'h0, 8'h0, 0);
    chk("abort_ff46_read", s_rdata, 8'hFF);

    // Random traffic against the model
    for (int j = 0; j < 1500; j++) begin
      sel = $urandom_range(0, 99);
      op  = $urandom_range(0, 3);
      case ($urandom_range(0, 5))
        0: ra = 16'(16'hC000 + $urandom_range(0, 16'h1FFF));
        1: ra = 16'(16'hE000 + $urandom_range(0, 16'h1DFF));
        2: ra = 16'(16'hFEA0 + $urandom_range(0, 16'h5F));
        3: ra = 16'(16'hFF80 + $urandom_range(0, 16'h7F));
        4: ra = 16'(16'hFE00 + $urandom_range(0, 16'hFF));
        default: ra = 16'($urandom_range(0, 16'hFFFF));
      endcase
      v = 8'($urandom_range(0, 255));
      if (sel < 1)
        step(0, 1, 16'hFF46, 8'($urandom_range(0, 8'hFD)), 0);
      else if (sel < 4)
        step(1, 0, 16'hFF46, 8'h0, 0);
      else
        step(op[0] | (op == 2), op[1], ra, v, 0);
    end
    idle(330);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
